// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute stage and the iterative multiply/divide unit.
// The core drives start/op/operands/cancel; the unit returns status and the HI/LO registers.
interface muldiv_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, cancel,
                   input  busy, done, div_by_zero, hi, lo);
   modport slave  (input  start, op, a, b, cancel,
                   output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO on HI/LO; one bit per cycle, WIDTH+1 cycles busy.
// No backpressure: start is taken only while idle, cancel aborts at once, MTHI/MTLO complete in one edge.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic [CW-1:0]      cnt;
   logic               op_div;
   logic               sa;
   logic               sb;
   logic               dz;
   logic               busy_q;
   logic               done_q;
   logic               dbz_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               is_signed;
   logic               is_div;
   logic               reserved;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   assign is_signed = ~bus.op[0];
   assign is_div    = bus.op[1];
   assign reserved  = bus.op[2] & bus.op[1];
   assign a_mag     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign b_mag     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   // Multiply: multiplier sits in acc low half and is consumed LSB first.
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
   assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

   // Restoring divide: partial remainder in the high half, quotient bits shift in at bit 0.
   assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
   assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

   assign prod = (sa ^ sb) ? -acc : acc;
   assign quo  = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem  = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         acc    <= '0;
         opnd   <= '0;
         cnt    <= '0;
         op_div <= 1'b0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         dz     <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         if (bus.cancel) begin
            state  <= IDLE;
            busy_q <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start && !reserved) begin
                     if (bus.op[2]) begin
                        if (bus.op[0]) lo_q <= bus.a;
                        else           hi_q <= bus.a;
                        done_q <= 1'b1;
                     end else begin
                        sa     <= is_signed & bus.a[WIDTH-1];
                        sb     <= is_signed & bus.b[WIDTH-1];
                        op_div <= is_div;
                        opnd   <= is_div ? b_mag : a_mag;
                        acc    <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                        cnt    <= '0;
                        dz     <= is_div && (bus.b == '0);
                        busy_q <= 1'b1;
                        state  <= (is_div && (bus.b == '0)) ? FIX : CALC;
                     end
                  end
               end
               CALC: begin
                  acc <= op_div ? div_next : mul_next;
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) state <= FIX;
               end
               FIX: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  if (dz) begin
                     dbz_q <= 1'b1;
                  end else if (op_div) begin
                     lo_q <= quo;
                     hi_q <= rem;
                  end else begin
                     hi_q <= prod[2*WIDTH-1:WIDTH];
                     lo_q <= prod[WIDTH-1:0];
                  end
               end
               default: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an arithmetic reference model checked every cycle, plus literal results.
module tb_muldiv_unit;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   muldiv_unit_if #(.WIDTH(W)) bus ();
   muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int vectors = 0;
   int miscompares = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result from plain 2W-bit arithmetic (truncating division, remainder follows dividend).
   function automatic void model_result(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                        output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
      logic signed [2*W-1:0] x, y, r;
      x = op[0] ? {{W{1'b0}}, a} : {{W{a[W-1]}}, a};
      y = op[0] ? {{W{1'b0}}, b} : {{W{b[W-1]}}, b};
      z = 1'b0;
      h = '0;
      l = '0;
      if (!op[1]) begin
         r = x * y;
         h = r[2*W-1:W];
         l = r[W-1:0];
      end else if (b == '0) begin
         z = 1'b1;
      end else begin
         r = x / y;
         l = r[W-1:0];
         r = x % y;
         h = r[W-1:0];
      end
   endfunction

   logic         m_busy, m_done, m_dz, p_dz;
   logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
   int           m_left;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
         m_hi = '0; m_lo = '0; m_left = 0;
      end else begin
         m_done = 1'b0;
         m_dz   = 1'b0;
         if (bus.cancel) begin
            m_left = 0;
            m_busy = 1'b0;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               if (p_dz) m_dz = 1'b1;
               else begin m_hi = p_hi; m_lo = p_lo; end
            end
         end else if (bus.start && !(bus.op[2] && bus.op[1])) begin
            case (bus.op)
               3'b100: begin m_hi = bus.a; m_done = 1'b1; end
               3'b101: begin m_lo = bus.a; m_done = 1'b1; end
               default: begin
                  model_result(bus.op, bus.a, bus.b, p_hi, p_lo, p_dz);
                  m_left = p_dz ? 1 : W + 1;
                  m_busy = 1'b1;
               end
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("busy", {{(W-1){1'b0}}, bus.busy}, {{(W-1){1'b0}}, m_busy});
         check("done", {{(W-1){1'b0}}, bus.done}, {{(W-1){1'b0}}, m_done});
         check("div_by_zero", {{(W-1){1'b0}}, bus.div_by_zero}, {{(W-1){1'b0}}, m_dz});
         check("hi", bus.hi, m_hi);
         check("lo", bus.lo, m_lo);
         check("busy_done_overlap", {{(W-1){1'b0}}, bus.busy & bus.done}, '0);
      end
   end

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name, output int nb);
      nb = 0;
      for (int i = 0; i < 200 && !bus.done; i++) begin
         if (bus.busy) nb++;
         @(negedge clk);
      end
      vectors++;
      if (!bus.done) begin
         miscompares++;
         $display("FAIL %s_timeout: done not seen within 200 cycles", name);
      end
   endtask

   task automatic expect_quiet(input string name, input int n);
      bit seen;
      seen = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      vectors++;
      if (seen) begin
         miscompares++;
         $display("FAIL %s: done rose, expected none", name);
      end
   endtask

   task automatic run(input string name, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input int exp_nb);
      int nb;
      issue(op, a, b);
      wait_done(name, nb);
      check({name, "_busy_cycles"}, nb, exp_nb);
      check({name, "_hi"}, bus.hi, exp_hi);
      check({name, "_lo"}, bus.lo, exp_lo);
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk_on = 1'b1;
      check("reset_busy", {{(W-1){1'b0}}, bus.busy}, '0);
      check("reset_hi", bus.hi, '0);
      check("reset_lo", bus.lo, '0);

      run("mult",     3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
      run("multu",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
      run("div_neg",  3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
      run("div_ovf",  3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
      run("divu",     3'b011, 32'd100,       32'd7,         32'd2,         32'd14,        33);
      run("mthi",     3'b100, 32'h1234,      32'd0,         32'h1234,      32'd14,        0);
      run("mtlo",     3'b101, 32'h5678,      32'd0,         32'h1234,      32'h5678,      0);
      run("divu_dz",  3'b011, 32'd55,        32'd0,         32'h1234,      32'h5678,      1);
      check("divu_dz_flag", {{(W-1){1'b0}}, bus.div_by_zero}, 32'd1);

      // Reserved op is ignored.
      issue(3'b110, 32'hAAAA, 32'h1);
      check("reserved_busy", {{(W-1){1'b0}}, bus.busy}, '0);

      // DIV in flight: MTLO start ignored, then cancel around iteration 10.
      issue(3'b010, 32'd1000, 32'd3);
      issue(3'b101, 32'hBEEF, 32'd0);
      repeat (7) @(negedge clk);
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.cancel = 1'b0;
      check("cancel_busy", {{(W-1){1'b0}}, bus.busy}, '0);
      expect_quiet("cancel_no_done", 40);
      check("cancel_hi", bus.hi, 32'h1234);
      check("cancel_lo", bus.lo, 32'h5678);

      // start together with cancel is dropped.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hDEAD; bus.cancel = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.cancel = 1'b0;
      check("start_cancel_done", {{(W-1){1'b0}}, bus.done}, '0);
      check("start_cancel_hi", bus.hi, 32'h1234);

      // Back-to-back: next accept at the edge where done is observed.
      run("divu_b2b", 3'b011, 32'd17, 32'd5, 32'd2, 32'd3, 33);
      run("multu_b2b", 3'b001, 32'd6, 32'd9, 32'd0, 32'd54, 33);

      // Reset mid-MULTU clears everything at once and no done follows.
      issue(3'b001, 32'd12345, 32'd678);
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_busy", {{(W-1){1'b0}}, bus.busy}, '0);
      check("rst_mid_hi", bus.hi, '0);
      check("rst_mid_lo", bus.lo, '0);
      @(negedge clk);
      reset = 1'b0;
      expect_quiet("rst_mid_no_done", 40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO result registers, the next-generation execute-stage companion for the pipelined MIPS core. It adds MULT, MULTU, DIV, DIVU, MTHI and MTLO, which the current core lacks, and its width is generic. The unit accepts one operation at a time through a start/busy/done handshake, computes one bit per cycle, and exposes HI/LO continuously for MFHI/MFLO forwarding. The core's hazard unit stalls MFHI/MFLO while `busy` is high and drives `cancel` on pipeline flush or exception.

## Interface
- `WIDTH`, default 32: operand, HI and LO width. Must be at least 2.
- `clk` in 1: clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request. Sampled at a rising edge only while idle.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. 110 and 111 are reserved.
- `a` in WIDTH: rs operand (dividend or multiplicand, MTHI/MTLO source).
- `b` in WIDTH: rt operand (divisor or multiplier).
- `cancel` in 1: synchronous abort.
- `busy` out 1: registered. High while an operation is in flight.
- `done` out 1: registered. One-cycle completion pulse.
- `div_by_zero` out 1: registered. High only together with `done` for a DIV/DIVU with `b`=0.
- `hi` out WIDTH: HI register. MULT upper half, or DIV remainder.
- `lo` out WIDTH: LO register. MULT lower half, or DIV quotient.

## Operation
- **States:** IDLE, CALC, FIX.
- **Internal state:**
  - 2·WIDTH-bit accumulator.
  - WIDTH-bit operand register.
  - $clog2(WIDTH)-bit iteration counter.
  - Latched op, latched sign flags `sa` and `sb`, and a `dz` flag.
- **Accept:** `start`=1, state IDLE, `cancel`=0, `op` not reserved. `start` in any other state, or with a reserved op, is ignored with no side effects.
- **Operands:** magnitudes are captured at accept.
  - Signed ops (MULT, DIV): absolute value of `a` and `b` in WIDTH-bit unsigned arithmetic, with `sa`/`sb` = operand MSBs.
  - Unsigned ops: raw operands, with `sa`=`sb`=0.
- **MTHI / MTLO:**
  - At the accept edge, `hi` (or `lo`) <= `a` and `done` <= 1.
  - `busy` never rises and the state stays IDLE.
- **MULT / MULTU:**
  - Accept edge: IDLE→CALC, counter=0.
  - Each CALC edge performs one shift-add step on the unsigned magnitudes.
  - After WIDTH steps (counter = WIDTH-1) the state goes to FIX.
  - FIX edge: the product is negated if `sa`^`sb`, then `{hi,lo}` <= product, `done` <= 1, state → IDLE.
- **DIV / DIVU with `b`≠0:**
  - Same sequencing, using restoring division, one quotient bit per CALC edge.
  - FIX edge: quotient negated if `sa`^`sb`, remainder negated if `sa`; `lo` <= quotient, `hi` <= remainder.
  - The most-negative value divided by -1 yields `lo` = most-negative and `hi` = 0. This is the natural result of the magnitude path and needs no special case.
- **Divide by zero:**
  - Accept edge goes IDLE→FIX directly with `dz`=1.
  - FIX edge: `hi` and `lo` unchanged, `done`=1, `div_by_zero`=1, state → IDLE.
- **`cancel`=1 at any edge:**
  - State → IDLE, `busy` <= 0, `done` <= 0.
  - `hi` and `lo` unchanged.
  - A simultaneous `start` is dropped; `cancel` has priority over accept and over the FIX writeback.
- **Hold:** `hi` and `lo` change only at the FIX writeback, on MTHI/MTLO, and at reset.

## Timing
- **Reset** (asynchronous, immediate): state IDLE; `busy`, `done`, `div_by_zero` = 0; `hi`=`lo`=0; counter and flags cleared. A reset mid-CALC aborts the operation with no `done`.
- **Busy window:** with the accept at edge k, `busy`=1 after edge k and through the cycle before edge k+WIDTH+1.
- **MULT/DIV:**
  - Results and `done` are visible after edge k+WIDTH+1.
  - `busy`=0 in that same cycle.
  - `done` drops after edge k+WIDTH+2 unless a new MTHI/MTLO is accepted there.
- **Divide by zero:** `busy`=1 for one cycle after edge k. `done` and `div_by_zero` are high after edge k+1.
- **MTHI/MTLO:** the register update and `done` are visible after edge k; latency is 1.
- **Back-to-back:** a new start can be accepted at the edge where `done` is raised is not allowed, because the state is FIX there. The earliest next accept is the edge at which `done`=1 is observed, which is state IDLE.
- **Handshake:** `done` is never high in the same cycle as `busy`.

## Test plan
- **Reset mid-operation:** WIDTH=32, MULTU start, then `reset` pulse after 10 cycles → `busy`=0 and `hi`=`lo`=0 immediately; no `done` follows.
- **MULT:** `a`=0xFFFFFFFD, `b`=7, start at edge k → `done`=1 after edge k+33; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high for exactly 33 cycles.
- **MULTU:** `a`=`b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **DIV:**
  - `a`=0xFFFFFFF9 (-7), `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - `a`=0x80000000, `b`=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - DIVU `a`=100, `b`=7 → `lo`=14, `hi`=2.
- **DIVU divide by zero:** `hi`=0x1234 and `lo`=0x5678 preset via MTHI/MTLO (each gives `done` after 1 edge), then DIVU with `b`=0 → `done`=`div_by_zero`=1 after edge k+1; `hi`/`lo` unchanged.
- **Cancel and ignored starts:**
  - DIV in flight, `start` MTLO asserted during CALC → ignored.
  - `cancel` at iteration 10 → `busy`=0 next cycle, no `done`, `hi`/`lo` unchanged.
  - `start`+`cancel` in the same cycle → nothing accepted.
